// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 keyboard definitions.
//   SC_*        scan-code constants for Enter, extended prefix and break prefix
//   ps2_state_e frame receiver FSM states
package ps2_pkg;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus stability filter for one raw PS/2 pin.
//   clk, reset  system clock, async active-low reset
//   line_i      raw asynchronous pin
//   filt_o      filtered level (resets to 1, the PS/2 idle level); changes only
//               after the synchronized level has differed for FILTER_LEN cycles
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic filt_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    // Any return to the current filtered level restarts the count.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync_q[1];
      else                   cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard frame receiver and key-event decoder.
//   clk, reset     100 MHz system clock, async active-low reset
//   ps2_clk/data   raw PS/2 pins
//   key_valid      one-cycle pulse, key_code/key_ext/key_release hold the event
//   enter          one-cycle pulse on the first make of Enter (with or without E0)
//   frame_err      one-cycle pulse when a frame is dropped (parity/stop/timeout)
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       enter,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  logic clk_f, data_f, clk_prev_q, sample;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .line_i(ps2_clk), .filt_o(clk_f));
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset(reset), .line_i(ps2_data), .filt_o(data_f));

  // Falling edge of the filtered PS/2 clock is the bit-sample event.
  assign sample = clk_prev_q & ~clk_f;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d, held_q, held_d;
  logic [7:0]    code_q, code_d;
  logic          kext_q, kext_d, krel_q, krel_d;
  logic          kv_q, kv_d, ent_q, ent_d, ferr_q, ferr_d;
  logic          byte_ok;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    held_d   = held_q;
    code_d   = code_q;
    kext_d   = kext_q;
    krel_d   = krel_q;
    kv_d     = 1'b0;
    ent_d    = 1'b0;
    ferr_d   = 1'b0;
    byte_ok  = 1'b0;

    if (state_q == IDLE || sample) to_cnt_d = '0;
    else                           to_cnt_d = to_cnt_q + TW'(1);

    if (state_q != IDLE && !sample && to_cnt_q == TO_MAX) begin
      ferr_d   = 1'b1;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      state_d  = IDLE;
      to_cnt_d = '0;
    end else if (sample) begin
      unique case (state_q)
        IDLE: if (!data_f) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
        DATA: begin
          shreg_d  = {data_f, shreg_q[7:1]};  // LSB arrives first
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_f;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_f && (^{shreg_q, par_q})) byte_ok = 1'b1;
          else begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (byte_ok) begin
      if (shreg_q == SC_EXT)        ext_d = 1'b1;
      else if (shreg_q == SC_BREAK) brk_d = 1'b1;
      else begin
        kv_d   = 1'b1;
        code_d = shreg_q;
        kext_d = ext_q;
        krel_d = brk_q;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
        // held flag suppresses enter on typematic repeats until release
        if (shreg_q == SC_ENTER) begin
          if (brk_q) held_d = 1'b0;
          else if (!held_q) begin
            ent_d  = 1'b1;
            held_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_q     <= 1'b0;
      code_q     <= '0;
      kext_q     <= 1'b0;
      krel_q     <= 1'b0;
      kv_q       <= 1'b0;
      ent_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_q     <= held_d;
      code_q     <= code_d;
      kext_q     <= kext_d;
      krel_q     <= krel_d;
      kv_q       <= kv_d;
      ent_q      <= ent_d;
      ferr_q     <= ferr_d;
    end
  end

  assign key_valid   = kv_q;
  assign key_code    = code_q;
  assign key_ext     = kext_q;
  assign key_release = krel_q;
  assign enter       = ent_q;
  assign frame_err   = ferr_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized PS/2 frame bench with a byte-level event model.
module tb_ps2_key_decoder;
  localparam int F    = 8;
  localparam int T    = 2000;
  localparam int HALF = 30;

  logic       clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       key_valid, key_ext, key_release, enter, frame_err;
  logic [7:0] key_code;

  ps2_key_decoder #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .enter(enter), .frame_err(frame_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    logic ext, rel, ent, err;
    int lo, hi;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int tests = 0, fails = 0;
  int ev_cnt = 0, enter_cnt = 0;
  bit m_ext = 0, m_brk = 0, m_held = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: every output pulse must match the head of the model queue.
  always @(negedge clk) if (reset) begin
    if (key_valid) ev_cnt++;
    if (enter) enter_cnt++;
    if (key_valid || frame_err) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event: got kv=%0b err=%0b code=%0h, expected none (cyc %0d)",
                 key_valid, frame_err, key_code, cyc);
      end else begin
        ce = q.pop_front();
        chk("ev_key_valid", key_valid, !ce.err);
        chk("ev_frame_err", frame_err, ce.err);
        chk("ev_enter", enter, ce.ent);
        if (!ce.err) begin
          chk("ev_code", key_code, ce.code);
          chk("ev_ext", key_ext, ce.ext);
          chk("ev_rel", key_release, ce.rel);
        end
        tests++;
        if (cyc < ce.lo || cyc > ce.hi) begin
          fails++;
          $display("FAIL ev_latency: got cyc %0d, expected %0d..%0d", cyc, ce.lo, ce.hi);
        end
      end
    end else if (enter) begin
      tests++; fails++;
      $display("FAIL enter_alone: got enter=1, expected 0 without key_valid (cyc %0d)", cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-level model: decide what one received frame must produce.
  task automatic model_frame(input logic [7:0] b, input bit bad, input int n);
    exp_t e;
    e.code = b; e.ext = m_ext; e.rel = m_brk; e.ent = 1'b0; e.err = bad;
    e.lo = n + F + 3; e.hi = e.lo;
    if (bad) begin
      m_ext = 0; m_brk = 0;
      q.push_back(e);
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (b == 8'h5A) begin
        e.ent  = !m_brk && !m_held;
        m_held = !m_brk;
      end
      m_ext = 0; m_brk = 0;
      q.push_back(e);
    end
  endtask

  // Drives nb bits LSB first; returns with ps2_clk low after the last bit.
  task automatic send_bits(input logic [10:0] bits, input int nb, output int n);
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      n = cyc;
      if (i < nb - 1) begin
        wait_cyc(HALF);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    logic par;
    int n;
    par  = ~(^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    send_bits(bits, 11, n);
    model_frame(b, bad_par | bad_stop, n);
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
  endtask

  initial begin
    int n, e0, v0;
    exp_t te;
    logic [7:0] b;
    logic [10:0] pb;

    wait_cyc(5);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_ext", key_ext, 0);
    chk("rst_key_release", key_release, 0);
    chk("rst_enter", enter, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    wait_cyc(20);

    // Single Enter make.
    send_frame(8'h5A, 0, 0);
    wait_cyc(20);
    chk("lit_5a_code", key_code, 8'h5A);
    chk("lit_5a_ev", ev_cnt, 1);
    chk("lit_5a_enter", enter_cnt, 1);

    // Release, then make, repeat, release, make: enter on the two fresh makes only.
    send_frame(8'hF0, 0, 0); send_frame(8'h5A, 0, 0);
    e0 = enter_cnt; v0 = ev_cnt;
    send_frame(8'h5A, 0, 0); send_frame(8'h5A, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h5A, 0, 0);
    send_frame(8'h5A, 0, 0);
    wait_cyc(20);
    chk("lit_seq_ev", ev_cnt - v0, 4);
    chk("lit_seq_enter", enter_cnt - e0, 2);

    // Extended make and break.
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    wait_cyc(20);
    chk("lit_e0f075", {key_code, key_ext, key_release}, {8'h75, 1'b1, 1'b1});

    // Bad parity then good frame.
    send_frame(8'h1C, 1, 0); send_frame(8'h1C, 0, 0);
    wait_cyc(20);
    chk("lit_1c_after_err", {key_code, key_release}, {8'h1C, 1'b0});

    // Truncated frame: start + 4 data bits, then silence past the timeout.
    pb = {6'b0, 4'b1010, 1'b0};
    send_bits(pb, 5, n);
    te.code = 0; te.ext = 0; te.rel = 0; te.ent = 0; te.err = 1;
    te.lo = n + T; te.hi = n + T + F + 6;
    q.push_back(te);
    wait_cyc(HALF);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(T + 100);
    chk("timeout_drained", q.size(), 0);
    send_frame(8'h1C, 0, 0);

    // Short clock glitches with data low must not start a frame.
    ps2_data = 1'b0;
    wait_cyc(HALF);
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0; wait_cyc(3);
      ps2_clk = 1'b1; wait_cyc(20);
    end
    ps2_data = 1'b1;
    wait_cyc(T + 100);
    v0 = ev_cnt;
    send_frame(8'h29, 0, 0);
    wait_cyc(20);
    chk("glitch_then_frame", {key_code, 8'(ev_cnt - v0)}, {8'h29, 8'd1});

    // Randomized frames.
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 5))
        0: b = 8'h5A;
        1: b = 8'hE0;
        2: b = 8'hF0;
        3: b = 8'h75;
        4: b = 8'h1C;
        default: b = 8'($urandom);
      endcase
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    wait_cyc(40);
    chk("random_drained", q.size(), 0);

    // Break prefix + partial frame, then async reset wipes all pending state.
    send_frame(8'hF0, 0, 0);
    send_bits(11'b000_0000_0110, 4, n);
    wait_cyc(5);
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs", {key_valid, key_code, key_ext, key_release, enter, frame_err}, 0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    m_ext = 0; m_brk = 0; m_held = 0;
    wait_cyc(HALF);
    chk("rst_hold_outputs", {key_valid, key_code, key_ext, key_release, enter, frame_err}, 0);
    reset = 1'b1;
    wait_cyc(20);
    e0 = enter_cnt;
    send_frame(8'h5A, 0, 0);
    wait_cyc(20);
    chk("post_rst_5a", {key_code, key_release}, {8'h5A, 1'b0});
    chk("post_rst_enter", enter_cnt - e0, 1);

    wait_cyc(50);
    chk("final_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames from the board's PS/2 port and turns them into single-cycle key events in the system clock domain. It also produces the one-cycle `enter` strobe that the start-screen and game-flow logic consume. It handles make, break (F0) and extended (E0) prefixes, odd parity, stop-bit checking and frame timeout. It sits between the raw `ps2_clk`/`ps2_data` pins and all game-side keyboard consumers.

## Interface
- FILTER_LEN, 8, consecutive `clk` cycles a synchronized PS/2 line must hold a new level before the filtered level changes
- TIMEOUT_CYC, 200000, `clk` cycles allowed between filtered `ps2_clk` falling edges inside a frame before abort (2 ms at 100 MHz)

- clk  input  1  system clock, 100 MHz
- reset  input  1  reset, asynchronous, active-low
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- ps2_data  input  1  raw PS/2 data pin, asynchronous
- key_valid  output  1  one-cycle pulse: a complete key event is on `key_code`/`key_ext`/`key_release`
- key_code  output  8  scan code of the event; holds its value until the next event
- key_ext  output  1  event was prefixed by E0
- key_release  output  1  event was prefixed by F0 (break)
- enter  output  1  one-cycle pulse on the first make of Enter (5A, with or without E0)
- frame_err  output  1  one-cycle pulse when a frame is dropped (parity, stop or timeout)

## Operation
- Reset values: all outputs 0; FSM in IDLE; `ext_pend`, `brk_pend` and `enter_held` cleared; filtered lines = 1.
- Each pin is synchronized with 2 FFs, then filtered. A falling edge of the filtered `ps2_clk` is a sample event; `ps2_data` is sampled (filtered value) on that event.
- FSM: IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample with data = 0 (start bit), go to DATA with bit count 0. A sample with data = 1 is ignored.
  - DATA: shift 8 bits LSB first; after the 8th bit, go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: require data = 1 and odd parity over 8 data bits + parity bit. If both hold, the byte is accepted. Otherwise pulse `frame_err`, clear both prefix flags, and drop the byte. Either way return to IDLE.
- Timeout: in any state other than IDLE, the counter is reset on every sample event. When it reaches TIMEOUT_CYC, pulse `frame_err`, clear prefix flags and return to IDLE.
- Accepted byte handling:
  - E0: set `ext_pend`; no event.
  - F0: set `brk_pend`; no event.
  - Any other byte: pulse `key_valid`, load `key_code` and set `key_ext` = `ext_pend`, `key_release` = `brk_pend`; then clear both flags.
- Enter rule:
  - On an event with `key_code` = 5A and release = 0 and `enter_held` = 0: pulse `enter` and set `enter_held`.
  - A release of 5A clears `enter_held`.
  - Typematic repeats of Enter produce `key_valid` but no `enter`.
- Async reset assertion mid-frame discards the partial frame and all flags immediately.

## Timing
- Filter latency: the filtered level changes FILTER_LEN cycles after the synchronized level first differs and then holds. Any glitch shorter than that is ignored. Pin-to-filtered latency is FILTER_LEN+2 cycles.
- `key_valid`, `enter` and `frame_err` assert exactly 1 `clk` cycle after the sample event that captures the stop bit, or after the timeout compare hits. Each is high for exactly 1 cycle.
- `key_code`, `key_ext` and `key_release` update in the same cycle as `key_valid` rises.
- `enter` is coincident with its `key_valid`.
- Back-to-back frames need no idle gap beyond the PS/2 stop bit; the block is ready for a new start bit in the cycle after STOP is processed.

## Structure
- Shared package `ps2_pkg`:
  - scan-code constants SC_ENTER = 8'h5A, SC_EXT = 8'hE0, SC_BREAK = 8'hF0
  - FSM state enum {IDLE, DATA, PARITY, STOP}
- Sub-module `ps2_line_filter` (2-FF sync + FILTER_LEN stability counter, output reset value 1), instantiated once for `ps2_clk` and once for `ps2_data`.
- Frame FSM, timeout counter and prefix/event logic stay in `ps2_key_decoder`.

## Test plan
- Frame 5A, valid parity, stop = 1 -> one `key_valid` with code 5A, ext = 0, release = 0, and `enter` in the same cycle; `frame_err` stays 0.
- Sequence 5A, 5A, F0 5A, 5A -> four `key_valid` pulses; `enter` pulses on the 1st and 4th only; the third event has `key_release` = 1.
- Sequence E0 75 then E0 F0 75 -> events (75, ext = 1, rel = 0) and (75, ext = 1, rel = 1); no `enter`.
- Frame 1C with bad parity, then a good frame 1C -> one `frame_err` pulse and no event for the first frame; a normal event for the second.
- Start bit plus 4 data bits, then silence > TIMEOUT_CYC -> a single `frame_err` pulse, FSM back in IDLE, and a following full frame decodes correctly. Also check that 3-cycle glitches on `ps2_clk` create no sample events.
- F0 received, then async reset asserted, then frame 5A -> outputs 0 during reset; after release the event is reported with release = 0 and `enter` pulses.
